// File: rtl/pwm_multi_pkg.sv
// pwm_multi_pkg: shared mode/direction types and reset values for the multi-channel PWM.
package pwm_multi_pkg;
    typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_e;
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} pwm_dir_e;
    localparam pwm_mode_e RST_MODE    = PWM_EDGE;
    localparam pwm_dir_e  RST_DIR     = DIR_UP;
    localparam logic      RST_PWM     = 1'b0;
    localparam logic      RST_PENDING = 1'b0;
endpackage

// File: rtl/pwm_multi_ch_out.sv
// pwm_multi_ch_out: one channel's shadow/active thresholds and registered compare/hold output.
module pwm_multi_ch_out
    import pwm_multi_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res_ni,
    input  logic             en_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_set_i,
    input  logic [WIDTH-1:0] wr_clr_i,
    input  logic             commit_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             set_ok_i,
    input  logic             clr_ok_i,
    output logic             pwm_o
);
    logic [WIDTH-1:0] set_sh, clr_sh, set_act, clr_act;

    always_ff @(posedge clk or negedge res_ni) begin
        if (!res_ni) begin
            set_sh  <= '0;
            clr_sh  <= '0;
            set_act <= '0;
            clr_act <= '0;
            pwm_o   <= RST_PWM;
        end else begin
            if (wr_en_i) begin
                set_sh <= wr_set_i;
                clr_sh <= wr_clr_i;
            end
            if (commit_i) begin
                set_act <= set_sh;
                clr_act <= clr_sh;
            end
            // clear has priority so set==clr settles at 0
            if (!en_i)
                pwm_o <= RST_PWM;
            else if (clr_ok_i && cnt_i == clr_act)
                pwm_o <= 1'b0;
            else if (set_ok_i && cnt_i == set_act)
                pwm_o <= 1'b1;
        end
    end
endmodule

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: N-channel edge/center-aligned PWM with shared counter and
// shadowed configuration committed atomically at a period boundary.
module pwm_multi_ch
    import pwm_multi_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int WIDTH = 8,
    localparam int CHW   = $clog2(NCH + 1)
) (
    input  logic             clk,
    input  logic             res_ni,
    input  logic             en_i,
    input  logic             wr_en_i,
    input  logic [CHW-1:0]   wr_ch_i,
    input  logic [WIDTH-1:0] wr_set_i,
    input  logic [WIDTH-1:0] wr_clr_i,
    input  logic             wr_mode_i,
    input  logic             update_req_i,
    output logic             update_pending_o,
    output logic             period_end_o,
    output logic [NCH-1:0]   pwm_o
);
    logic [WIDTH-1:0] cnt, per, per_sh;
    pwm_mode_e        mode, mode_sh;
    pwm_dir_e         dir;
    logic             wrap, commit, up_eff, set_ok, clr_ok;

    always_comb begin
        up_eff = dir == DIR_UP || cnt == per;
        wrap   = per == '0 || (mode == PWM_EDGE ? cnt == per :
                 (dir == DIR_DOWN && cnt == WIDTH'(1)) || (dir == DIR_UP && per == WIDTH'(1) && cnt == per));
        commit = update_pending_o && (wrap || !en_i);
        set_ok = mode == PWM_EDGE || up_eff;
        clr_ok = mode == PWM_EDGE || !up_eff;
    end

    always_ff @(posedge clk or negedge res_ni) begin
        if (!res_ni) begin
            cnt              <= '0;
            dir              <= RST_DIR;
            per              <= '0;
            per_sh           <= '0;
            mode             <= RST_MODE;
            mode_sh          <= RST_MODE;
            update_pending_o <= RST_PENDING;
            period_end_o     <= 1'b0;
        end else begin
            if (wr_en_i && wr_ch_i == CHW'(NCH)) begin
                per_sh  <= wr_set_i;
                mode_sh <= pwm_mode_e'(wr_mode_i);
            end
            if (commit) begin
                per  <= per_sh;
                mode <= mode_sh;
            end
            update_pending_o <= update_req_i || (update_pending_o && !commit);
            period_end_o     <= en_i && wrap;
            // every wrap (and so every commit) restarts the period at 0/up
            if (!en_i || wrap) begin
                cnt <= '0;
                dir <= DIR_UP;
            end else if (mode == PWM_EDGE) begin
                cnt <= cnt + 1'b1;
            end else if (dir == DIR_UP && cnt == per) begin
                cnt <= cnt - 1'b1;
                dir <= DIR_DOWN;
            end else begin
                cnt <= dir == DIR_UP ? cnt + 1'b1 : cnt - 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_multi_ch_out #(.WIDTH(WIDTH)) u_ch (
            .clk      (clk),
            .res_ni   (res_ni),
            .en_i     (en_i),
            .wr_en_i  (wr_en_i && wr_ch_i == CHW'(i)),
            .wr_set_i (wr_set_i),
            .wr_clr_i (wr_clr_i),
            .commit_i (commit),
            .cnt_i    (cnt),
            .set_ok_i (set_ok),
            .clr_ok_i (clr_ok),
            .pwm_o    (pwm_o[i])
        );
    end
endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: table-driven duty/period checks, directed corner sequences and
// randomized traffic against a period-position reference model.
module tb_pwm_multi_ch;
    localparam int NCH = 4, WIDTH = 8, CHW = $clog2(NCH + 1);

    logic clk = 0, res_n = 0, en = 0, wr_en = 0, wr_mode = 0, req = 0;
    logic [CHW-1:0]   wr_ch  = '0;
    logic [WIDTH-1:0] wr_set = '0, wr_clr = '0;
    logic             upd_pend, pe;
    logic [NCH-1:0]   pwm;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    pwm_multi_ch #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk(clk), .res_ni(res_n), .en_i(en), .wr_en_i(wr_en), .wr_ch_i(wr_ch),
        .wr_set_i(wr_set), .wr_clr_i(wr_clr), .wr_mode_i(wr_mode), .update_req_i(req),
        .update_pending_o(upd_pend), .period_end_o(pe), .pwm_o(pwm)
    );

    // reference model: position t within the period, cnt and direction derived arithmetically
    int m_t = 0, sh_p = 0, ac_p = 0;
    bit sh_m = 0, ac_m = 0, m_pend = 0, m_pe = 0;
    logic [NCH-1:0] m_pwm = '0;
    int sh_set[NCH], sh_clr[NCH], ac_set[NCH], ac_clr[NCH];

    initial forever begin
        int len, c, idx;
        bit up, wrap, commit;
        @(posedge clk or negedge res_n);
        if (!res_n) begin
            m_t = 0; sh_p = 0; ac_p = 0; sh_m = 0; ac_m = 0; m_pend = 0; m_pe = 0; m_pwm = '0;
            for (int i = 0; i < NCH; i++) begin
                sh_set[i] = 0; sh_clr[i] = 0; ac_set[i] = 0; ac_clr[i] = 0;
            end
        end else begin
            len  = ac_p == 0 ? 1 : ac_m ? 2 * ac_p : ac_p + 1;
            up   = m_t <= ac_p;
            c    = up ? m_t : 2 * ac_p - m_t;
            wrap = m_t == len - 1;
            for (int i = 0; i < NCH; i++) begin
                if (!en) m_pwm[i] = 1'b0;
                else if (c == ac_clr[i] && (!ac_m || !up)) m_pwm[i] = 1'b0;
                else if (c == ac_set[i] && (!ac_m || up)) m_pwm[i] = 1'b1;
            end
            m_pe   = en && wrap;
            commit = m_pend && (wrap || !en);
            m_t    = (!en || wrap) ? 0 : m_t + 1;
            if (commit) begin
                ac_p = sh_p; ac_m = sh_m;
                for (int i = 0; i < NCH; i++) begin
                    ac_set[i] = sh_set[i]; ac_clr[i] = sh_clr[i];
                end
            end
            idx = int'(wr_ch);
            if (wr_en && idx < NCH) begin
                sh_set[idx] = int'(wr_set); sh_clr[idx] = int'(wr_clr);
            end else if (wr_en && idx == NCH) begin
                sh_p = int'(wr_set); sh_m = wr_mode;
            end
            m_pend = req || (m_pend && !commit);
        end
    end

    initial forever begin
        @(negedge clk);
        checks++;
        if ({pwm, pe, upd_pend} !== {m_pwm, m_pe, m_pend}) begin
            failures++;
            $display("FAIL model_cycle t=%0t got pwm=%b pe=%b pend=%b expected pwm=%b pe=%b pend=%b",
                     $time, pwm, pe, upd_pend, m_pwm, m_pe, m_pend);
        end
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        failures++;
        $display("FAIL %s: timeout got no event expected event", name);
    endtask

    task automatic idle();
        wr_en = 0;
        req = 0;
    endtask

    task automatic wr(int ch, int s, int c, bit m);
        wr_en = 1; wr_ch = CHW'(ch); wr_set = WIDTH'(s); wr_clr = WIDTH'(c); wr_mode = m;
    endtask

    task automatic cfg(bit m, int p, int ch, int s, int c);
        int n = 0;
        @(negedge clk) wr(NCH, p, 0, m);
        @(negedge clk) wr(ch, s, c, 0); req = 1;
        @(negedge clk) idle();
        while (upd_pend && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (upd_pend) timeout("cfg_commit");
    endtask

    task automatic wait_pe();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pe && n < 2000);
        if (!pe) timeout("wait_pe");
    endtask

    task automatic count_period(int ch, output int len, output int high);
        len = 0;
        high = 0;
        do begin
            @(negedge clk);
            len++;
            if (((pwm >> ch) & NCH'(1)) != '0) high++;
        end while (!pe && len < 2000);
        if (!pe) timeout("count_period");
    endtask

    typedef struct { bit mode; int p, ch, s, c, exp_len, exp_high; } rec_t;
    rec_t recs[9];

    initial begin
        int len, high;
        recs[0] = '{0,   9, 0, 2,   7,  10,   5};
        recs[1] = '{1,   8, 1, 3,   3,  16,  10};
        recs[2] = '{0,   9, 0, 2,   4,  10,   2};
        recs[3] = '{0,   0, 3, 0,   0,   1,   0};
        recs[4] = '{0,   0, 3, 0,   1,   1,   1};
        recs[5] = '{1,   4, 2, 1,   2,   8,   5};
        recs[6] = '{0, 255, 1, 0, 128, 256, 128};
        recs[7] = '{0,   6, 0, 3,   3,   7,   0};
        recs[8] = '{1,   1, 2, 0,   1,   2,   2};

        repeat (3) @(negedge clk);
        check("rst_pwm", int'(pwm), 0);
        check("rst_period_end", int'(pe), 0);
        check("rst_pending", int'(upd_pend), 0);
        res_n = 1;
        en = 1;

        for (int i = 0; i < 9; i++) begin
            cfg(recs[i].mode, recs[i].p, recs[i].ch, recs[i].s, recs[i].c);
            wait_pe();
            count_period(recs[i].ch, len, high);
            count_period(recs[i].ch, len, high);
            check($sformatf("rec%0d_period", i), len, recs[i].exp_len);
            check($sformatf("rec%0d_high", i), high, recs[i].exp_high);
        end

        // shadow write without request leaves duty unchanged until committed
        cfg(0, 9, 0, 2, 7);
        wait_pe();
        repeat (4) @(negedge clk);
        wr(0, 2, 4, 0);
        @(negedge clk) idle();
        wait_pe();
        count_period(0, len, high);
        check("shadow_only_high", high, 5);
        check("shadow_only_pending", int'(upd_pend), 0);
        req = 1;
        @(negedge clk) idle();
        check("req_pending", int'(upd_pend), 1);
        wait_pe();
        check("req_pending_cleared", int'(upd_pend), 0);
        count_period(0, len, high);
        check("req_new_high", high, 2);

        // request and write landing in the commit cycle
        wait_pe();
        @(negedge clk) wr(2, 2, 7, 0); req = 1;
        @(negedge clk) idle();
        repeat (7) @(negedge clk);
        wr(2, 2, 4, 0);
        req = 1;
        @(negedge clk) idle();
        check("commit_cycle_pe", int'(pe), 1);
        check("commit_cycle_pending", int'(upd_pend), 1);
        count_period(2, len, high);
        check("commit_cycle_old_high", high, 5);
        check("commit_cycle_pending_done", int'(upd_pend), 0);
        count_period(2, len, high);
        check("commit_cycle_new_high", high, 2);

        // asynchronous reset in center mode with a commit pending
        cfg(1, 8, 1, 3, 3);
        wait_pe();
        @(negedge clk) req = 1;
        @(negedge clk) idle();
        repeat (4) @(negedge clk);
        check("pre_reset_pwm1", int'(pwm[1]), 1);
        check("pre_reset_pending", int'(upd_pend), 1);
        #1 res_n = 0;
        #1;
        check("async_rst_pwm", int'(pwm), 0);
        check("async_rst_pe", int'(pe), 0);
        check("async_rst_pending", int'(upd_pend), 0);
        @(negedge clk) res_n = 1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_pe", int'(pe), 1);
            check("post_rst_pwm", int'(pwm), 0);
        end

        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            en = $urandom_range(0, 31) != 0;
            if ($urandom_range(0, 2) == 0)
                wr(int'($urandom_range(0, 7)),
                   $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12)),
                   $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12)),
                   1'($urandom_range(0, 1)));
            else
                wr_en = 0;
            req = $urandom_range(0, 7) == 0;
        end
        @(negedge clk) idle();
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
N-channel PWM generator with a common WIDTH-bit period counter and per-channel set/clear thresholds. Edge-aligned (sawtooth) and center-aligned (triangle) modes. Configuration is written into shadow registers and committed atomically at a period boundary, so channels never see a half-updated configuration. Sits in the timer/PWM subsystem as the next-generation replacement for the single-channel 8-bit PWM.

Parameters:
NCH, 4, number of PWM channels (1..16)
WIDTH, 8, counter/threshold width in bits (4..16)
CHW, $clog2(NCH+1), derived width of the channel-select field; not to be overridden

Ports:
clk  in  1  clock; all inputs are synchronous to it
res_ni  in  1  reset, asynchronous, active-low
en_i  in  1  counter enable; low = counter held, outputs forced low
wr_en_i  in  1  shadow write strobe, single-cycle
wr_ch_i  in  CHW  target channel; value NCH selects the period/mode shadow
wr_set_i  in  WIDTH  set threshold (period value when wr_ch_i==NCH)
wr_clr_i  in  WIDTH  clear threshold (ignored when wr_ch_i==NCH)
wr_mode_i  in  1  0=edge, 1=center; used only when wr_ch_i==NCH
update_req_i  in  1  pulse: arm commit of shadows to active at next period end
update_pending_o  out  1  commit armed, not yet done
period_end_o  out  1  one-cycle pulse in the wrap cycle
pwm_o  out  NCH  PWM outputs, registered

Behaviour:
- Reset: cnt=0, dir=up, all shadows and actives 0, mode=edge, pwm_o=0, update_pending_o=0, period_end_o=0.
- Write: wr_en_i && wr_ch_i<NCH -> shadow set/clr[ch] updated next edge. wr_ch_i==NCH -> shadow period/mode updated. wr_ch_i>NCH -> ignored. Active registers are never written directly.
- Edge mode, P=active period: cnt 0,1,..,P,0,... Wrap cycle: cnt==P. Period is P+1 cycles.
- Center mode: cnt 0,1,..,P,P-1,..,1,0,... At cnt==P and up: dir<=down, next P-1. At cnt==1 and down: next 0, dir<=up. Wrap cycle: cnt==1 and down, or cnt==P==1 and up. Period is 2P cycles.
- P==0, either mode: cnt stays 0; every cycle is a wrap cycle.
- period_end_o: registered; asserted the cycle after the wrap cycle.
- Channel output: registered, one-cycle latency from the compare, evaluated against the current cnt.
  - Edge mode: cnt==clr -> 0; else cnt==set -> 1; else hold. Clear wins on equality.
  - Center mode: set match is honoured only while dir=up; clear match only while dir=down; clear priority is kept. At cnt==P, the match counts as up.
- Commit:
  - update_req_i sets the pending flag.
  - In a wrap cycle with pending=1: every active register <= its shadow, pending cleared, next cnt=0, dir=up (overrides the normal next value).
  - update_req_i asserted in the commit cycle: pending stays 1, so the next period commits again.
  - wr_en_i in the commit cycle: the old shadow is copied to active; the new value lands in the shadow only.
- en_i low: cnt<=0, dir<=up, pwm_o<=0, period_end_o=0. A pending commit occurs on the first disabled cycle.
- en_i rising: counting resumes from 0/up with the active configuration.
- Thresholds > P never match, so the channel holds its level. set==clr -> constant 0 after the first match.
- Counter arithmetic is modulo 2^WIDTH. P=2^WIDTH-1 is legal: edge-mode wrap to 0 is natural.

Decomposition:
- Package pwm_multi_pkg: mode enum (PWM_EDGE, PWM_CENTER), direction enum (DIR_UP, DIR_DOWN), reset-value constants.
- Sub-module pwm_multi_ch_out: one channel's shadow/active threshold pair plus its compare/hold output flop. Instantiated NCH times via generate.
- Top level holds the counter, direction, period/mode registers, pending flag and commit strobe.

Test Plan:
- Edge mode, period 9 (P=9), ch0 set=2 clr=7, commit, en=1 -> pwm_o[0] high exactly 5 of every 10 cycles; rises the cycle after cnt==2; period_end_o every 10 cycles.
- Center mode, P=8, ch1 set=3 clr=3 -> cnt sequence 0..8..1 repeating, period 16; pwm_o[1] high from the cycle after up-count 3 until the cycle after down-count 3 (10 cycles).
- Change ch0 clr 7->4 via shadow mid-period, no update_req -> output unchanged. Pulse update_req -> update_pending_o=1 until the wrap, then new duty (2 cycles) from the next period.
- update_req_i in the commit cycle together with a wr_en_i to ch2 -> old ch2 value committed; pending stays 1; new ch2 value committed at the following wrap.
- P=0 with set=0 clr=0, then set=0 clr=1 -> pwm_o=0 and period_end_o every cycle; then constant 1 after the second commit.
- Assert res_ni low mid-period in center mode with pending=1 -> all outputs 0 immediately; pending cleared; after release, edge mode with P=0.
